ball_ctrl: RTL
==============

BALL_CTRL -- requirements
Module: ball_ctrl

Interface
REQ-001 SHALL have parameter H_SIZE, default 5: ball half-size in pixels.
REQ-002 SHALL have parameter IX, default 320: parked/reset centre x.
REQ-003 SHALL have parameter IY, default 400: reset centre y.
REQ-004 SHALL have parameter IX_DIR, default 1: serve x direction (1 right, 0 left).
REQ-005 SHALL have parameter D_WIDTH, default 640, and D_HEIGHT, default 480: display size.
REQ-006 SHALL have parameter LIVES, default 3: lives per game (1-3).
REQ-007 SHALL have parameter LOST_FRAMES, default 60: pause after ball loss, in strobes.
REQ-008 SHALL have ports, with one clock and an asynchronous, active-low reset:
- i_clk  in  1  base clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ani_stb  in  1  one-cycle frame strobe
- i_animate  in  1  motion enable
- i_start  in  1  serve / restart request (level)
- i_hit_block  in  2  OR of all block hit codes: 00 none, 10 x-flip, 01 y-flip, 11 both
- i_p_x1, i_p_x2, i_p_y1  in  12 each  paddle left, right and top edges
- o_x, o_y  out  12 each  ball centre
- o_x1, o_x2, o_y1, o_y2  out  12 each  ball edges, combinational from centre ±H_SIZE
- o_col_detected  out  1  one-cycle hit acknowledge to blocks
- o_lives  out  2  lives remaining
- o_state  out  2  00 IDLE, 01 MOVE, 10 LOST, 11 OVER

Function
REQ-009 SHALL update position only on cycles where i_ani_stb=1 and i_animate=1 (a "step").
REQ-010 IDLE: each step SHALL set o_x=(i_p_x1+i_p_x2)>>1 (13-bit sum) and o_y=i_p_y1-H_SIZE-1; i_start=1 SHALL go to MOVE with y direction up and x direction IX_DIR.
REQ-011 MOVE: each step SHALL move the ball by STEP pixels on each axis in its current directions; STEP=1 unless REQ-021 applies.
REQ-012 Wall rules, evaluated on the post-move position, SHALL force direction absolutely and never toggle it:
- x<=H_SIZE+1 -> right
- x>=D_WIDTH-H_SIZE-1 -> left
- y<=H_SIZE+1 -> down
REQ-013 Paddle rule: moving down, o_y+H_SIZE>=i_p_y1, o_y<i_p_y1 and i_p_x1<=o_x<=i_p_x2 SHALL force y direction up.
REQ-014 o_y>=D_HEIGHT-H_SIZE-1 in MOVE SHALL decrement o_lives (saturating at 0) and go to LOST.
REQ-015 In MOVE, in any cycle (step or not), i_hit_block!=00 with ack_wait=0 SHALL apply a toggle: 10 flips x, 01 flips y, 11 flips both. It SHALL pulse o_col_detected for exactly one cycle and set ack_wait.
REQ-016 ack_wait SHALL clear in the first cycle i_hit_block==00; no further hit is applied while it is set.
REQ-017 A hit and a step in the same cycle: the toggle SHALL apply first, then wall/paddle forcing (REQ-012/013) SHALL override it.
REQ-018 LOST: i_hit_block SHALL be ignored; after LOST_FRAMES steps go to OVER if o_lives==0, else to IDLE.
REQ-019 OVER: ball SHALL be held; i_start=1 SHALL reload o_lives=LIVES and go to IDLE.

Reset
REQ-020 i_rst_n=0 SHALL asynchronously set: state IDLE; o_x=IX; o_y=IY; x direction IX_DIR; y direction up; o_lives=LIVES; o_col_detected=0; ack_wait=0; LOST and hit counters 0; STEP=1. A mid-MOVE reset SHALL abort the motion.

Configuration
REQ-021 With BALL_SPEEDUP_EN defined, a hit counter SHALL increment per applied hit, and STEP SHALL become 2 after 8 hits. STEP SHALL return to 1 and the counter clear on entry to IDLE. Without the macro, STEP SHALL be fixed at 1 and no counter is built.

Verification
REQ-022 Reset, then release with paddle 290..350, top 440, and 3 strobes -> o_x=320, o_y=434, o_state=00, o_lives=3.
REQ-023 i_start, ball at x=633 moving right, one step -> x=634, x direction left; next step -> x=633.
REQ-024 In MOVE, hold i_hit_block=10 for 3 cycles -> o_col_detected high for 1 cycle only, a single x flip; drop to 00, then 01 -> y flip plus a second pulse.
REQ-025 Hit 01 on the same cycle as a step reaching y=6 -> y direction down, not up.
REQ-026 Ball reaches y=474 with lives 1 -> state LOST, lives 0; 60 steps later -> OVER; i_start -> lives 3, IDLE.
REQ-027 BALL_SPEEDUP_EN defined, 8 hits -> subsequent steps move 2 pixels per axis; without the macro, still 1.

Source files
------------

// File: rtl/ball_ctrl.sv
`default_nettype none
// ==========================================================================
// ball_ctrl : ball motion, wall/paddle/block bounce, lives and game state.
// Optional feature macro BALL_SPEEDUP_EN: step doubles after 8 block hits.
// Rev 1.0
// ==========================================================================
module ball_ctrl #(
  parameter int H_SIZE      = 5,
  parameter int IX          = 320,
  parameter int IY          = 400,
  parameter int IX_DIR      = 1,
  parameter int D_WIDTH     = 640,
  parameter int D_HEIGHT    = 480,
  parameter int LIVES       = 3,
  parameter int LOST_FRAMES = 60
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ani_stb,
  input  logic        i_animate,
  input  logic        i_start,
  input  logic [1:0]  i_hit_block,
  input  logic [11:0] i_p_x1,
  input  logic [11:0] i_p_x2,
  input  logic [11:0] i_p_y1,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic [11:0] o_x1,
  output logic [11:0] o_x2,
  output logic [11:0] o_y1,
  output logic [11:0] o_y2,
  output logic        o_col_detected,
  output logic [1:0]  o_lives,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MOVE = 2'b01,
    S_LOST = 2'b10,
    S_OVER = 2'b11
  } state_t;

  localparam int          LW     = $clog2(LOST_FRAMES + 1);
  localparam logic [11:0] c_h    = 12'(H_SIZE);
  localparam logic [11:0] c_xmin = 12'(H_SIZE + 1);
  localparam logic [11:0] c_xmax = 12'(D_WIDTH - H_SIZE - 1);
  localparam logic [11:0] c_ymin = 12'(H_SIZE + 1);
  localparam logic [11:0] c_ybot = 12'(D_HEIGHT - H_SIZE - 1);

  state_t          r_state;
  logic            r_dx;        // 1 = right
  logic            r_dy_down;   // 1 = down
  logic            r_ack_wait;
  logic [LW-1:0]   r_lost_cnt;

  logic            w_is_step;
  logic            w_hit_apply;
  logic            w_dx;
  logic            w_dy;
  logic            w_ndx;
  logic            w_ndy;
  logic [11:0]     w_step;
  logic [11:0]     w_nx;
  logic [11:0]     w_ny;
  logic [12:0]     w_psum;
  logic [11:0]     w_idle_y;
  logic            w_lost_done;
  logic            w_to_idle;

  assign o_state = r_state;
  assign o_x1    = o_x - c_h;
  assign o_x2    = o_x + c_h;
  assign o_y1    = o_y - c_h;
  assign o_y2    = o_y + c_h;

`ifdef BALL_SPEEDUP_EN
  logic [3:0] r_hit_cnt;

  assign w_step = r_hit_cnt[3] ? 12'd2 : 12'd1;

  // Saturates at 8; only the threshold matters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit_cnt <= 4'd0;
    end else if (w_to_idle) begin
      r_hit_cnt <= 4'd0;
    end else if (w_hit_apply && !r_hit_cnt[3]) begin
      r_hit_cnt <= r_hit_cnt + 4'd1;
    end
  end
`else
  assign w_step = 12'd1;
`endif

  always_comb begin
    w_is_step   = i_ani_stb & i_animate;
    w_hit_apply = (r_state == S_MOVE) && (i_hit_block != 2'b00) && !r_ack_wait;
    w_dx        = r_dx      ^ (w_hit_apply & i_hit_block[1]);
    w_dy        = r_dy_down ^ (w_hit_apply & i_hit_block[0]);
    // Motion uses the directions held before this cycle's hit toggle.
    w_nx        = r_dx      ? (o_x + w_step) : (o_x - w_step);
    w_ny        = r_dy_down ? (o_y + w_step) : (o_y - w_step);
    w_ndx       = w_dx;
    w_ndy       = w_dy;
    if (w_nx <= c_xmin) begin
      w_ndx = 1'b1;
    end else if (w_nx >= c_xmax) begin
      w_ndx = 1'b0;
    end
    if (w_ny <= c_ymin) begin
      w_ndy = 1'b1;
    end
    if (w_ndy && (({1'b0, w_ny} + {1'b0, c_h}) >= {1'b0, i_p_y1}) &&
        (w_ny < i_p_y1) && (i_p_x1 <= w_nx) && (w_nx <= i_p_x2)) begin
      w_ndy = 1'b0;
    end
    w_psum      = {1'b0, i_p_x1} + {1'b0, i_p_x2};
    w_idle_y    = i_p_y1 - 12'(H_SIZE + 1);
    w_lost_done = (r_state == S_LOST) && w_is_step &&
                  (r_lost_cnt == LW'(LOST_FRAMES - 1));
    w_to_idle   = (w_lost_done && (o_lives != 2'd0)) ||
                  ((r_state == S_OVER) && i_start);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      o_x            <= 12'(IX);
      o_y            <= 12'(IY);
      r_dx           <= 1'(IX_DIR);
      r_dy_down      <= 1'b0;
      o_lives        <= 2'(LIVES);
      o_col_detected <= 1'b0;
      r_ack_wait     <= 1'b0;
      r_lost_cnt     <= '0;
    end else begin
      o_col_detected <= 1'b0;
      if (i_hit_block == 2'b00) begin
        r_ack_wait <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_is_step) begin
            o_x <= w_psum[12:1];
            o_y <= w_idle_y;
          end
          if (i_start) begin
            r_state   <= S_MOVE;
            r_dx      <= 1'(IX_DIR);
            r_dy_down <= 1'b0;
          end
        end
        S_MOVE: begin
          if (w_hit_apply) begin
            o_col_detected <= 1'b1;
            r_ack_wait     <= 1'b1;
          end
          r_dx      <= w_dx;
          r_dy_down <= w_dy;
          if (w_is_step) begin
            o_x       <= w_nx;
            o_y       <= w_ny;
            r_dx      <= w_ndx;
            r_dy_down <= w_ndy;
            if (w_ny >= c_ybot) begin
              r_state    <= S_LOST;
              r_lost_cnt <= '0;
              o_lives    <= (o_lives != 2'd0) ? (o_lives - 2'd1) : 2'd0;
            end
          end
        end
        S_LOST: begin
          if (w_lost_done) begin
            r_lost_cnt <= '0;
            r_state    <= (o_lives == 2'd0) ? S_OVER : S_IDLE;
          end else if (w_is_step) begin
            r_lost_cnt <= r_lost_cnt + 1'b1;
          end
        end
        S_OVER: begin
          if (i_start) begin
            o_lives <= 2'(LIVES);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
